// File: rtl/palette_compositor.sv
// Indexed-colour compositor: per-layer palette lookup, then priority selection of the first opaque layer.
// Fixed two-cycle latency with no backpressure; palettes sit in inferred block RAM and are never reset.
module palette_compositor #(
  parameter int unsigned NUM_LAYERS = 3,
  parameter int unsigned IDX_W      = 8,
  parameter int unsigned TRANSP_IDX = 0,
  parameter logic [23:0] BG_COLOR   = 24'h800080,
  localparam int unsigned LAYER_W   = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic                        in_valid,
  input  logic [NUM_LAYERS-1:0]       in_active,
  input  logic [NUM_LAYERS*IDX_W-1:0] in_idx,
  input  logic                        in_blank,
  input  logic                        frame_start,
  input  logic [NUM_LAYERS-1:0]       layer_en_next,
  input  logic                        pal_we,
  input  logic [LAYER_W-1:0]          pal_layer,
  input  logic [IDX_W-1:0]            pal_addr,
  input  logic [23:0]                 pal_wdata,
  output logic                        out_valid,
  output logic [7:0]                  VGA_R,
  output logic [7:0]                  VGA_G,
  output logic [7:0]                  VGA_B,
  output logic [NUM_LAYERS-1:0]       layer_en
);

  logic [NUM_LAYERS-1:0]       opaque_p0;
  logic [NUM_LAYERS-1:0][23:0] color_p1;
  logic [NUM_LAYERS-1:0]       opaque_p1;
  logic                        vld_p1;
  logic                        blank_p1;
  logic [23:0]                 pick_p1;
  logic                        vld_p2;
  logic [23:0]                 rgb_p2;

  // Lowest-numbered opaque layer wins; blanking overrides everything.
  function automatic logic [23:0] pick_color(
    input logic [NUM_LAYERS-1:0]       opaque,
    input logic [NUM_LAYERS-1:0][23:0] colors,
    input logic                        blank
  );
    logic [23:0] c;
    c = BG_COLOR;
    for (int k = int'(NUM_LAYERS) - 1; k >= 0; k--) begin
      if (opaque[k]) c = colors[k];
    end
    if (blank) c = 24'h000000;
    return c;
  endfunction

  // ---- stage 0 -> 1: palette read (read-before-write on collision) and opaque flags
  for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_pal
    logic [23:0] mem [2**IDX_W];
    logic [23:0] rd_p1;
    logic        we;

    assign we = pal_we && (pal_layer == LAYER_W'(k));

    always_ff @(posedge Clk) begin
      if (we) mem[pal_addr] <= pal_wdata;
      rd_p1 <= mem[in_idx[k*IDX_W +: IDX_W]];
    end

    assign color_p1[k]  = rd_p1;
    assign opaque_p0[k] = in_active[k] & layer_en[k] &
                          (in_idx[k*IDX_W +: IDX_W] != IDX_W'(TRANSP_IDX));
  end

  always_comb begin
    pick_p1 = pick_color(opaque_p1, color_p1, blank_p1);
  end

  // ---- stage 1 -> 2: composited colour, held while no pixel is valid
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      layer_en  <= '1;
      vld_p1    <= 1'b0;
      blank_p1  <= 1'b0;
      opaque_p1 <= '0;
      vld_p2    <= 1'b0;
      rgb_p2    <= '0;
    end else begin
      if (frame_start) layer_en <= layer_en_next;
      vld_p1    <= in_valid;
      blank_p1  <= in_blank;
      opaque_p1 <= opaque_p0;
      vld_p2    <= vld_p1;
      if (vld_p1) rgb_p2 <= pick_p1;
    end
  end

  assign out_valid = vld_p2;
  assign VGA_R     = rgb_p2[23:16];
  assign VGA_G     = rgb_p2[15:8];
  assign VGA_B     = rgb_p2[7:0];

endmodule

// File: tb/tb_palette_compositor.sv
// Scoreboard bench for palette_compositor: a reference palette/mask model predicts each pixel's colour.
module tb_palette_compositor;

  localparam int NL = 3;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [NL-1:0] in_active = '0;
  logic [23:0]   in_idx = '0;
  logic          in_blank = 1'b0;
  logic          frame_start = 1'b0;
  logic [NL-1:0] layer_en_next = '1;
  logic          pal_we = 1'b0;
  logic [1:0]    pal_layer = '0;
  logic [7:0]    pal_addr = '0;
  logic [23:0]   pal_wdata = '0;
  logic          out_valid;
  logic [7:0]    VGA_R, VGA_G, VGA_B;
  logic [NL-1:0] layer_en;

  int n_pass = 0;
  int n_total = 0;
  logic [23:0] sb[$];
  logic [23:0] model_pal [NL][256];
  logic [NL-1:0] model_en = '1;
  logic [23:0] last_rgb = '0;

  palette_compositor dut (
    .Clk(Clk), .Reset_n(Reset_n), .in_valid(in_valid), .in_active(in_active),
    .in_idx(in_idx), .in_blank(in_blank), .frame_start(frame_start),
    .layer_en_next(layer_en_next), .pal_we(pal_we), .pal_layer(pal_layer),
    .pal_addr(pal_addr), .pal_wdata(pal_wdata), .out_valid(out_valid),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .layer_en(layer_en)
  );

  always #5 Clk = ~Clk;

  // Scoreboard monitor: every out_valid must match the oldest outstanding prediction.
  always @(negedge Clk) begin
    if (Reset_n && out_valid) begin
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_out_valid: got rgb %h with no pixel outstanding", {VGA_R, VGA_G, VGA_B});
      end else begin
        logic [23:0] e;
        e = sb.pop_front();
        if ({VGA_R, VGA_G, VGA_B} !== e)
          $display("FAIL pixel_rgb: got %h, expected %h", {VGA_R, VGA_G, VGA_B}, e);
        else
          n_pass++;
        last_rgb = e;
      end
    end
  end

  function automatic logic [23:0] model_color();
    logic [23:0] c;
    c = 24'h800080;
    for (int k = 0; k < NL; k++) begin
      logic [7:0] ix;
      ix = in_idx[k*8 +: 8];
      if (in_active[k] && model_en[k] && ix != 8'd0) begin
        c = model_pal[k][ix];
        break;
      end
    end
    if (in_blank) c = 24'h000000;
    return c;
  endfunction

  // Advance one cycle: predict from pre-edge state, then apply writes/mask to the model.
  task automatic step();
    if (in_valid) sb.push_back(model_color());
    if (pal_we && pal_layer < NL) model_pal[pal_layer][pal_addr] = pal_wdata;
    if (frame_start) model_en = layer_en_next;
    @(negedge Clk);
    in_valid = 1'b0; pal_we = 1'b0; frame_start = 1'b0; in_blank = 1'b0;
  endtask

  task automatic set_px(input logic [2:0] act, input logic [7:0] i0, i1, i2, input logic blank);
    in_valid = 1'b1; in_active = act; in_idx = {i2, i1, i0}; in_blank = blank;
  endtask

  task automatic set_wr(input logic [1:0] l, input logic [7:0] a, input logic [23:0] d);
    pal_we = 1'b1; pal_layer = l; pal_addr = a; pal_wdata = d;
  endtask

  task automatic drain();
    int budget;
    budget = 10;
    while (sb.size() != 0 && budget > 0) begin
      step();
      budget--;
    end
    n_total++;
    if (sb.size() != 0) begin
      $display("FAIL drain_timeout: got %0d pixels outstanding, expected 0", sb.size());
      sb.delete();
    end else n_pass++;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge Clk);
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b, expected 0", out_valid); else n_pass++;
    n_total++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'h0) $display("FAIL reset_rgb: got %h, expected 000000", {VGA_R, VGA_G, VGA_B}); else n_pass++;
    n_total++;
    if (layer_en !== 3'b111) $display("FAIL reset_layer_en: got %b, expected 111", layer_en); else n_pass++;
    Reset_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    set_wr(2'd0, 8'd5, 24'hA80000); step();
    set_px(3'b001, 8'd5, 8'd0, 8'd0, 1'b0); step();
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL latency_early: got out_valid %b, expected 0", out_valid); else n_pass++;
    step();
    n_total++;
    if (out_valid !== 1'b1) $display("FAIL latency_two: got out_valid %b, expected 1", out_valid); else n_pass++;
    n_total++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'hA80000) $display("FAIL basic_rgb: got %h, expected a80000", {VGA_R, VGA_G, VGA_B}); else n_pass++;
    drain();
  endtask

  task automatic test_priority();
    set_wr(2'd1, 8'd2, 24'hF8F0F8); step();
    set_wr(2'd0, 8'd3, 24'h404838); step();
    set_wr(2'd2, 8'd9, 24'h123456); step();
    set_px(3'b011, 8'd0, 8'd2, 8'd0, 1'b0); step();
    set_px(3'b011, 8'd3, 8'd2, 8'd0, 1'b0); step();
    set_px(3'b100, 8'd3, 8'd2, 8'd9, 1'b0); step();
    set_px(3'b111, 8'd0, 8'd0, 8'd9, 1'b0); step();
    set_px(3'b110, 8'd3, 8'd2, 8'd9, 1'b0); step();
    drain();
    n_total++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'hF8F0F8) $display("FAIL priority_last: got %h, expected f8f0f8", {VGA_R, VGA_G, VGA_B}); else n_pass++;
  endtask

  task automatic test_bg_blank();
    set_px(3'b000, 8'd3, 8'd2, 8'd9, 1'b0); step();
    set_px(3'b000, 8'd3, 8'd2, 8'd9, 1'b1); step();
    set_px(3'b111, 8'd3, 8'd2, 8'd9, 1'b1); step();
    set_px(3'b111, 8'd0, 8'd0, 8'd0, 1'b0); step();
    drain();
    n_total++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'h800080) $display("FAIL bg_all_transparent: got %h, expected 800080", {VGA_R, VGA_G, VGA_B}); else n_pass++;
  endtask

  task automatic test_hold();
    set_px(3'b001, 8'd5, 8'd0, 8'd0, 1'b0); step();
    drain();
    in_valid = 1'b0; in_active = 3'b111; in_idx = {8'd9, 8'd2, 8'd3}; in_blank = 1'b1;
    repeat (3) @(negedge Clk);
    in_blank = 1'b0;
    n_total++;
    if ({VGA_R, VGA_G, VGA_B} !== last_rgb) $display("FAIL rgb_hold: got %h, expected %h", {VGA_R, VGA_G, VGA_B}, last_rgb); else n_pass++;
  endtask

  task automatic test_collision();
    set_wr(2'd0, 8'd7, 24'h111111); step();
    set_wr(2'd0, 8'd7, 24'h222222); set_px(3'b001, 8'd7, 8'd0, 8'd0, 1'b0); step();
    set_px(3'b001, 8'd7, 8'd0, 8'd0, 1'b0); step();
    set_wr(2'd1, 8'd5, 24'h0A0B0C); step();
    set_wr(2'd2, 8'd5, 24'h0D0E0F); step();
    set_wr(2'd3, 8'd5, 24'hFFFFFF); step();
    set_px(3'b001, 8'd5, 8'd5, 8'd5, 1'b0); step();
    set_px(3'b010, 8'd5, 8'd5, 8'd5, 1'b0); step();
    set_px(3'b100, 8'd5, 8'd5, 8'd5, 1'b0); step();
    drain();
    n_total++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'h0D0E0F) $display("FAIL ignored_write: got %h, expected 0d0e0f", {VGA_R, VGA_G, VGA_B}); else n_pass++;
  endtask

  task automatic test_layer_en();
    layer_en_next = 3'b110;
    set_px(3'b011, 8'd5, 8'd2, 8'd0, 1'b0); step();
    step();
    n_total++;
    if (layer_en !== 3'b111) $display("FAIL mask_no_frame: got %b, expected 111", layer_en); else n_pass++;
    set_px(3'b011, 8'd5, 8'd2, 8'd0, 1'b0); frame_start = 1'b1; step();
    set_px(3'b011, 8'd5, 8'd2, 8'd0, 1'b0); step();
    set_px(3'b001, 8'd5, 8'd2, 8'd0, 1'b0); step();
    n_total++;
    if (layer_en !== 3'b110) $display("FAIL mask_applied: got %b, expected 110", layer_en); else n_pass++;
    drain();
    n_total++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'h800080) $display("FAIL masked_to_bg: got %h, expected 800080", {VGA_R, VGA_G, VGA_B}); else n_pass++;
    layer_en_next = 3'b111; frame_start = 1'b1; step();
  endtask

  task automatic test_reset_mid();
    set_px(3'b001, 8'd5, 8'd0, 8'd0, 1'b0); step();
    set_px(3'b011, 8'd0, 8'd2, 8'd0, 1'b0); step();
    set_px(3'b010, 8'd0, 8'd2, 8'd0, 1'b0); step();
    layer_en_next = 3'b010; frame_start = 1'b1;
    #1 Reset_n = 1'b0;
    #1;
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL async_reset_valid: got %b, expected 0", out_valid); else n_pass++;
    n_total++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'h0) $display("FAIL async_reset_rgb: got %h, expected 000000", {VGA_R, VGA_G, VGA_B}); else n_pass++;
    n_total++;
    if (layer_en !== 3'b111) $display("FAIL async_reset_mask: got %b, expected 111", layer_en); else n_pass++;
    sb.delete();
    @(negedge Clk);
    frame_start = 1'b0; layer_en_next = 3'b111; model_en = '1;
    Reset_n = 1'b1;
    repeat (4) step();
    set_px(3'b001, 8'd5, 8'd0, 8'd0, 1'b0); step();
    drain();
    n_total++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'hA80000) $display("FAIL palette_retained: got %h, expected a80000", {VGA_R, VGA_G, VGA_B}); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_bg_blank();
    test_hold();
    test_collision();
    test_layer_en();
    test_reset_mid();
    repeat (3) @(negedge Clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/palette_compositor.md
PALETTE_COMPOSITOR -- requirements
Module: palette_compositor

Interface
REQ-001 Parameter NUM_LAYERS, default 3: number of indexed layers; layer 0 has the highest priority.
REQ-002 Parameter IDX_W, default 8: palette index width; each layer palette holds 2**IDX_W entries of 24 bits.
REQ-003 Parameter TRANSP_IDX, default 0: index treated as transparent on every layer.
REQ-004 Parameter BG_COLOR, default 24'h800080: colour output when no layer is opaque.
REQ-005 Clk  input  1  single clock for all logic.
REQ-006 Reset_n  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  pixel request valid this cycle.
REQ-008 in_active  input  NUM_LAYERS  per-layer "pixel lies inside layer" flags.
REQ-009 in_idx  input  NUM_LAYERS*IDX_W  per-layer palette indices; layer k occupies bits [k*IDX_W +: IDX_W].
REQ-010 in_blank  input  1  pixel is in the blanking interval.
REQ-011 frame_start  input  1  one-cycle pulse at frame boundary (vsync edge).
REQ-012 layer_en_next  input  NUM_LAYERS  requested layer enable mask, applied at the next frame_start.
REQ-013 pal_we  input  1  palette write strobe.
REQ-014 pal_layer  input  $clog2(NUM_LAYERS) (minimum 1)  target palette of the write.
REQ-015 pal_addr  input  IDX_W  write address.
REQ-016 pal_wdata  input  24  write colour {R,G,B}.
REQ-017 out_valid  output  1  VGA_R/G/B are valid.
REQ-018 VGA_R, VGA_G, VGA_B  output  8 each  composited colour, registered.
REQ-019 layer_en  output  NUM_LAYERS  currently applied enable mask.

Function
REQ-020 The pipeline SHALL be fixed-latency, with no backpressure: request accepted at cycle N produces out_valid and its colour at cycle N+2.
REQ-021 Stage 1 SHALL register the synchronous palette read for every layer, together with in_valid, in_blank, and a per-layer opaque flag.
- Opaque flag = in_active[k] & layer_en[k] & (in_idx[k] != TRANSP_IDX).
REQ-022 Stage 2 SHALL register the colour of the lowest-numbered opaque layer.
- If no layer is opaque, it SHALL register BG_COLOR.
- If the stage-1 blank flag is set, it SHALL register 24'h000000 regardless of the layers.
REQ-023 out_valid SHALL be in_valid delayed by exactly 2 cycles.
- When out_valid=0, the RGB outputs SHALL hold their previous values.
REQ-024 A palette write SHALL update only entry pal_addr of palette pal_layer, on the rising edge where pal_we=1.
- If pal_layer >= NUM_LAYERS, the write SHALL be ignored.
REQ-025 Write/read collision on the same layer and address in the same cycle SHALL be read-before-write: that pixel sees the old colour; a read one cycle later sees the new colour.
REQ-026 Palette writes SHALL be accepted every cycle, independent of in_valid and in_blank.
REQ-027 layer_en SHALL load layer_en_next only on a cycle with frame_start=1; otherwise it SHALL hold its value.
REQ-028 If frame_start coincides with in_valid, the pixel in that cycle SHALL use the old layer_en; the new mask applies from the next cycle.
REQ-029 Palettes SHALL map to inferred block RAM.
- Palette contents are not reset and are undefined until written.
- Any out-of-range index bits are impossible by width, so no wrap handling is needed.

Reset
REQ-030 While Reset_n=0, the block SHALL force:
- out_valid=0 and VGA_R/G/B=0;
- layer_en = all ones;
- all pipeline valid and opaque flags = 0.
REQ-031 Reset asserted mid-frame SHALL discard in-flight pixels; the first out_valid after release SHALL come 2 cycles after the first accepted in_valid.
REQ-032 Palette RAM contents SHALL be retained across reset.

Verification
REQ-033 Write layer 0 addr 5 = 24'hA80000, then drive in_valid, in_active=3'b001, idx0=5 -> 2 cycles later out_valid=1, RGB = A8/00/00.
REQ-034 Layers 0 and 1 both active, idx0=0 (transparent), layer 1 addr 2 = 24'hF8F0F8 -> output F8/F0/F8; set idx0=3 with layer 0 addr 3 = 24'h404838 -> output 40/48/38.
REQ-035 No layer active -> output 80/00/80; same request with in_blank=1 -> output 00/00/00.
REQ-036 Same cycle: pal_we to layer 0 addr 7 (old 24'h111111, new 24'h222222) and a pixel reading idx0=7 -> pixel shows 11/11/11; next cycle same read -> 22/22/22.
REQ-037 layer_en_next=3'b110 without frame_start -> layer 0 still displayed; pulse frame_start together with a pixel -> that pixel uses the old mask, the next shows layer 1 or BG; layer_en reads 3'b110.
REQ-038 Assert Reset_n=0 with 2 pixels in flight -> out_valid=0 and RGB=0 immediately (asynchronously), layer_en=3'b111; after release, a previously written palette entry still reads back correctly.
